// File: rtl/rr_arbiter8.sv
// Eight-way round-robin arbiter with bounded grant hold time.
// Grants are registered one-hot; every release inserts one idle cycle.
module rr_arbiter8 #(
  parameter int unsigned HOLD_LIMIT = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] req,
  input  logic       done,
  output logic [7:0] grant,
  output logic       busy,
  output logic       timeout
);

  typedef enum logic {
    IDLE,
    GRANT
  } state_e;

  state_e     state_q, state_d;
  logic [7:0] grant_q, grant_d;
  logic       busy_q, busy_d;
  logic       timeout_q, timeout_d;
  logic [2:0] ptr_q, ptr_d;
  logic [2:0] owner_q, owner_d;
  logic [7:0] cnt_q, cnt_d;

  logic [2:0] pick;
  logic [2:0] idx;
  logic       found;
  logic       own_req;
  logic       limit_hit;
  logic       release_now;

  // Scan from ptr upward, wrapping mod 8; first hit wins.
  always_comb begin
    pick  = '0;
    idx   = '0;
    found = 1'b0;
    for (int i = 0; i < 8; i++) begin
      idx = ptr_q + 3'(i);
      if (!found && req[idx]) begin
        found = 1'b1;
        pick  = idx;
      end
    end
  end

  assign own_req     = req[owner_q];
  assign limit_hit   = (cnt_q == 8'(HOLD_LIMIT - 1));
  assign release_now = done || !own_req || limit_hit;

  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    busy_d    = busy_q;
    timeout_d = 1'b0;
    ptr_d     = ptr_q;
    owner_d   = owner_q;
    cnt_d     = cnt_q;
    unique case (state_q)
      IDLE: begin
        grant_d = '0;
        busy_d  = 1'b0;
        if (found) begin
          grant_d = 8'(1) << pick;
          busy_d  = 1'b1;
          cnt_d   = '0;
          owner_d = pick;
          state_d = GRANT;
        end
      end
      GRANT: begin
        if (release_now) begin
          grant_d   = '0;
          busy_d    = 1'b0;
          ptr_d     = owner_q + 3'd1;
          state_d   = IDLE;
          // Timeout only when the hold limit alone forced release.
          timeout_d = limit_hit && !done && own_req;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      default: begin
        state_d = IDLE;
        grant_d = '0;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      grant_q   <= '0;
      busy_q    <= 1'b0;
      timeout_q <= 1'b0;
      ptr_q     <= '0;
      owner_q   <= '0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      busy_q    <= busy_d;
      timeout_q <= timeout_d;
      ptr_q     <= ptr_d;
      owner_q   <= owner_d;
      cnt_q     <= cnt_d;
    end
  end

  assign grant   = grant_q;
  assign busy    = busy_q;
  assign timeout = timeout_q;

endmodule

// File: tb/tb_rr_arbiter8.sv
// Randomized scoreboard bench for rr_arbiter8.
// Reference model tracks owner/pointer/hold as plain integers.
module tb_rr_arbiter8;

  localparam int HL = 4;

  logic       clk;
  logic       rst_n;
  logic [7:0] req;
  logic       done;
  logic [7:0] grant;
  logic       busy;
  logic       timeout;

  rr_arbiter8 #(.HOLD_LIMIT(HL)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .req    (req),
    .done   (done),
    .grant  (grant),
    .busy   (busy),
    .timeout(timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [9:0] exp_q[$];
  int  checks;
  int  errors;
  bit  started;

  int  m_owner;
  int  m_ptr;
  int  m_held;
  bit  m_to;

  function automatic void model_step(input logic [7:0] r,
                                     input logic d,
                                     input logic rs);
    logic [7:0] g;
    bit ra, rb, rc;
    if (!rs) begin
      m_owner = -1;
      m_ptr   = 0;
      m_held  = 0;
      m_to    = 0;
    end else if (m_owner < 0) begin
      m_to = 0;
      for (int k = 0; k < 8; k++) begin
        if (m_owner < 0 && r[(m_ptr + k) % 8]) begin
          m_owner = (m_ptr + k) % 8;
          m_held  = 1;
        end
      end
    end else begin
      ra = d;
      rb = !r[m_owner];
      rc = (m_held >= HL);
      if (ra || rb || rc) begin
        m_to    = rc && !ra && !rb;
        m_ptr   = (m_owner + 1) % 8;
        m_owner = -1;
      end else begin
        m_held = m_held + 1;
        m_to   = 0;
      end
    end
    g = (m_owner < 0) ? 8'h00 : (8'(1) << m_owner);
    exp_q.push_back({g, (m_owner >= 0), m_to});
  endfunction

  task automatic cyc(input logic [7:0] r,
                     input logic d,
                     input logic rs);
    @(negedge clk);
    req   = r;
    done  = d;
    rst_n = rs;
    model_step(r, d, rs);
    started = 1'b1;
  endtask

  always @(posedge clk) begin
    logic [9:0] e;
    #1;
    if (started) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sb_empty: no expected entry at %0t", $time);
      end else begin
        e = exp_q.pop_front();
        checks++;
        if (grant !== e[9:2]) begin
          errors++;
          $display("FAIL grant @%0t: got %h want %h", $time, grant, e[9:2]);
        end
        checks++;
        if (busy !== e[1]) begin
          errors++;
          $display("FAIL busy @%0t: got %b want %b", $time, busy, e[1]);
        end
        checks++;
        if (timeout !== e[0]) begin
          errors++;
          $display("FAIL timeout @%0t: got %b want %b", $time, timeout, e[0]);
        end
        checks++;
        if ($countones(grant) > 1) begin
          errors++;
          $display("FAIL onehot @%0t: got %h want <=1 bit", $time, grant);
        end
      end
    end
  end

  initial begin
    logic [7:0] r;
    logic       d;
    logic       rs;
    checks  = 0;
    errors  = 0;
    started = 1'b0;
    m_owner = -1;
    m_ptr   = 0;
    m_held  = 0;
    m_to    = 0;
    rst_n   = 1'b0;
    req     = 8'hFF;
    done    = 1'b0;

    // reset then rotation with done held
    repeat (2) cyc(8'hFF, 1'b0, 1'b0);
    repeat (18) cyc(8'hFF, 1'b1, 1'b1);

    // pointer: grant 5, release, then 0 beats 5
    cyc(8'h00, 1'b0, 1'b0);
    repeat (2) cyc(8'h20, 1'b0, 1'b1);
    cyc(8'h20, 1'b1, 1'b1);
    repeat (3) cyc(8'h21, 1'b0, 1'b1);

    // timeout with a single held requester
    cyc(8'h00, 1'b0, 1'b0);
    repeat (12) cyc(8'h08, 1'b0, 1'b1);

    // owner drop
    cyc(8'h00, 1'b0, 1'b0);
    repeat (2) cyc(8'h08, 1'b0, 1'b1);
    cyc(8'h00, 1'b0, 1'b1);
    cyc(8'h00, 1'b0, 1'b1);

    // done coinciding with the hold limit
    repeat (4) cyc(8'h08, 1'b0, 1'b1);
    cyc(8'h08, 1'b1, 1'b1);
    repeat (2) cyc(8'h08, 1'b0, 1'b1);

    // owner drop coinciding with the hold limit
    cyc(8'h00, 1'b0, 1'b0);
    repeat (4) cyc(8'h04, 1'b0, 1'b1);
    cyc(8'h00, 1'b0, 1'b1);
    cyc(8'h00, 1'b0, 1'b1);

    // mid-grant reset
    cyc(8'h00, 1'b0, 1'b0);
    repeat (2) cyc(8'h10, 1'b0, 1'b1);
    cyc(8'hFF, 1'b0, 1'b0);
    repeat (3) cyc(8'hFF, 1'b0, 1'b1);

    r = 8'h00;
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 3) == 0) begin
        r = 8'($urandom);
        if ($urandom_range(0, 2) == 0) r = r & 8'($urandom);
      end
      d  = ($urandom_range(0, 5) == 0);
      rs = ($urandom_range(0, 99) != 0);
      cyc(r, d, rs);
    end

    @(posedge clk);
    #2;
    started = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/rr_arbiter8.md
RR_ARBITER8 -- requirements
Module: rr_arbiter8

Interface
REQ-001 SHALL have parameter HOLD_LIMIT, default 16, the maximum consecutive cycles one grant is held (legal range 2..255).
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state updates on rising edge.
REQ-003 SHALL have port rst_n, input, 1 bit: one clock; reset is synchronous and active-low.
REQ-004 SHALL have port req, input, 8 bits: request per requester, bit i = requester i, level-sensitive.
REQ-005 SHALL have port done, input, 1 bit: single-cycle release pulse from the current owner.
REQ-006 SHALL have port grant, output, 8 bits, registered: one-hot or all-zero grant, consumed directly by the downstream 8-to-3 one-hot-to-index decoder.
REQ-007 SHALL have port busy, output, 1 bit, registered: high exactly while grant is non-zero.
REQ-008 SHALL have port timeout, output, 1 bit, registered: one-cycle pulse when a grant is revoked by HOLD_LIMIT.

Function
REQ-009 SHALL implement a two-state FSM: IDLE (grant=0) and GRANT (grant one-hot).
REQ-010 SHALL keep a 3-bit priority pointer ptr; the highest priority is requester ptr, then ptr+1, ... ptr+7, all mod 8.
REQ-011 In IDLE with req!=0 at a rising edge: SHALL set grant to the one-hot bit of the first requester found from ptr upward, set busy=1, clear the hold counter, and go to GRANT.
REQ-012 In IDLE with req==0: SHALL stay in IDLE with grant=0; done is ignored.
REQ-013 Grant latency SHALL be exactly one edge: req sampled at edge k -> grant visible after edge k.
REQ-014 grant SHALL never have more than one bit set; $countones(grant) is 0 or 1 in every cycle.
REQ-015 In GRANT, release SHALL occur at the first edge where (a) done=1, (b) req[owner]=0, or (c) grant has been high HOLD_LIMIT cycles.
REQ-016 On release: grant=0 and busy=0 after that edge, ptr=owner+1 mod 8 (7 wraps to 0), FSM returns to IDLE.
REQ-017 Between two consecutive owners (including the same owner re-granted), grant SHALL be 0 for exactly one cycle when requests remain pending.
REQ-018 Hold counter: 8 bits, counts cycles with grant high, saturates never (cleared on every grant).
REQ-019 timeout SHALL be 1 for exactly the one cycle after a release caused only by (c); 0 otherwise.
REQ-020 Simultaneous release causes: if (c) coincides with (a) or (b), timeout SHALL be 0.
REQ-021 Changes to req bits other than the owner's during GRANT SHALL not affect grant.
REQ-022 A requester with req held continuously SHALL be granted within 8 grant periods (starvation-free).

Reset
REQ-023 When rst_n=0 at a rising edge: grant=8'h00, busy=0, timeout=0, ptr=0, hold counter=0, FSM=IDLE, regardless of state or inputs.
REQ-024 Reset asserted mid-GRANT SHALL drop grant at that edge without a timeout pulse; no state survives.
REQ-025 First edge with rst_n=1 SHALL behave as IDLE per REQ-011.

Verification
REQ-026 Reset: req=8'hFF, rst_n=0 for 2 cycles -> grant=0, busy=0, timeout=0; first edge after release -> grant=8'h01.
REQ-027 Rotation: req=8'hFF, done pulsed each GRANT cycle -> grant sequence 01,00,02,00,04,...,80,00,01 (wrap 7->0).
REQ-028 Pointer: from reset, req=8'h20 then done -> grant 20, ptr=6; then req=8'h21 -> grant=8'h01.
REQ-029 Timeout: HOLD_LIMIT=4, req=8'h08 held, done=0 -> grant=08 for 4 cycles, then grant=0 with timeout=1 for 1 cycle, then grant=08 again.
REQ-030 Owner drop and coincidence: owner req falls -> grant=0 next edge, timeout=0; done on the HOLD_LIMIT-th cycle -> timeout=0.
REQ-031 Mid-grant reset: grant=8'h10, rst_n=0 one cycle with req=8'hFF -> grant=0, timeout=0, then grant=8'h01.
